data_cache: RTL and testbench

- Direct-mapped, write-through, write-no-allocate data cache.
- Sits directly downstream of the datapath MEM stage, between the MEM-stage address/data/request signals and main data memory.
- Hides a fixed multi-cycle memory latency behind a single combinational stall, which the hazard logic ORs into the pipeline stall.

---
 rtl/cache_pkg.sv | 44 ++++
 rtl/data_cache_if.sv | 17 +
 rtl/cache_tag_data_array.sv | 44 ++++
 rtl/data_cache.sv | 144 ++++++++++++++
 tb/tb_data_cache.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
//   - geometry constants (LINES, INDEX_BITS, TAG_BITS, XLEN)
//   - controller state encoding
//   - helpers splitting a byte address into tag / index / byte offset
package cache_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned LINES           = 8;
  localparam int unsigned INDEX_BITS      = $clog2(LINES);
  localparam int unsigned TAG_BITS        = XLEN - INDEX_BITS - 2;
  localparam int unsigned MEM_LATENCY_DEF = 4;
  localparam int unsigned CNT_BITS        = 8;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [CNT_BITS-1:0]   cnt_t;

  typedef struct packed {
    tag_t       tag;
    index_t     index;
    logic [1:0] offset;
  } addr_t;

  function automatic tag_t get_tag(input logic [XLEN-1:0] addr);
    addr_t a;
    a = addr_t'(addr);
    return a.tag;
  endfunction

  function automatic index_t get_index(input logic [XLEN-1:0] addr);
    addr_t a;
    a = addr_t'(addr);
    return a.index;
  endfunction

  function automatic logic [1:0] get_offset(input logic [XLEN-1:0] addr);
    addr_t a;
    a = addr_t'(addr);
    return a.offset;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Memory-side bus between the data cache and main data memory.
//   mem_addr     : word-aligned address
//   mem_data_in  : bytes towards memory, element 0 = bits 7:0
//   mem_data_out : bytes from memory, element 0 = bits 7:0
//   mem_we       : per-byte write enable
// master = cache, slave = memory.
interface data_cache_if;
  import cache_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic [7:0]      mem_data_in  [0:3];
  logic [7:0]      mem_data_out [0:3];
  logic [3:0]      mem_we;

  modport master (output mem_addr, mem_data_in, mem_we, input mem_data_out);
  modport slave  (input mem_addr, mem_data_in, mem_we, output mem_data_out);
endinterface

// File: rtl/cache_tag_data_array.sv
// Valid/tag/data storage for the direct-mapped cache.
//   rd_index/rd_tag -> rd_hit, rd_data : combinational lookup
//   wr_en/wr_index/wr_tag/wr_be/wr_data : synchronous write, sets the valid bit
//   rst_b clears all valid bits asynchronously; tags and data keep their contents.
module cache_tag_data_array
  import cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  index_t          rd_index,
  input  tag_t            rd_tag,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  index_t          wr_index,
  input  tag_t            wr_tag,
  input  logic [3:0]      wr_be,
  input  logic [XLEN-1:0] wr_data
);

  logic [LINES-1:0] valid;
  tag_t             tag_mem  [LINES];
  logic [XLEN-1:0]  data_mem [LINES];

  assign rd_hit  = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_data = data_mem[rd_index];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)     valid <= '0;
    else if (wr_en) valid[wr_index] <= 1'b1;
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits alone decide
  // whether their contents mean anything, so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index] <= wr_tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-no-allocate data cache for the MEM stage.
//   cpu_addr/cpu_wdata/cpu_read/cpu_write/cpu_byte/halted : request from MEM stage
//   cpu_rdata : hit word (0 when no hit), cpu_stall : combinational pipeline freeze
//   mem       : memory bus (data_cache_if.master), registered drive
//   hit_count/miss_count : saturating load hit/miss counters
// A load miss stalls for 1 + MEM_LATENCY cycles and then hits on retry.
// A store holds mem_we for MEM_LATENCY + 1 cycles, then releases the stall once
// (write_done) so the frozen store is not issued a second time.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic            cpu_byte,
  input  logic            halted,
  output logic [XLEN-1:0] cpu_rdata,
  output logic            cpu_stall,
  data_cache_if.master    mem,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
);

  localparam cnt_t LAT = cnt_t'(MEM_LATENCY);

  state_t          state;
  cnt_t            counter;
  logic            write_done;
  logic            rd_hit;
  logic [XLEN-1:0] rd_data;
  logic            wr_en;
  logic [3:0]      wr_be;
  logic [XLEN-1:0] wr_data;

  // Store wins when both strobes are up; halted masks every new request.
  wire do_write = !halted && cpu_write;
  wire do_read  = !halted && cpu_read && !cpu_write;

  wire fill_last  = (state == FILL)  && (counter == LAT);
  wire write_last = (state == WRITE) && (counter == LAT);

  // Fill writes the whole line; a store updates the line only if it is resident.
  assign wr_en   = fill_last || (write_last && rd_hit);
  assign wr_be   = fill_last ? 4'hF : mem.mem_we;
  assign wr_data = fill_last
                 ? {mem.mem_data_out[3], mem.mem_data_out[2], mem.mem_data_out[1], mem.mem_data_out[0]}
                 : {mem.mem_data_in[3],  mem.mem_data_in[2],  mem.mem_data_in[1],  mem.mem_data_in[0]};

  cache_tag_data_array u_array (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_index (get_index(cpu_addr)),
    .rd_tag   (get_tag(cpu_addr)),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (get_index(cpu_addr)),
    .wr_tag   (get_tag(cpu_addr)),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  assign cpu_rdata = rd_hit ? rd_data : '0;

  always_comb begin
    // NOTE: default first so every path assigns cpu_stall and no latch is inferred.
    cpu_stall = 1'b0;
    case (state)
      IDLE: begin
        if (do_write)     cpu_stall = !write_done;
        else if (do_read) cpu_stall = !rd_hit;
      end
      FILL, WRITE: cpu_stall = 1'b1;
      default:     cpu_stall = 1'b0;
    endcase
    // The frozen request may still be on the bus while reset is asserted.
    if (!rst_b) cpu_stall = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      counter      <= '0;
      write_done   <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      mem.mem_addr <= '0;
      mem.mem_we   <= '0;
      for (int i = 0; i < 4; i++) mem.mem_data_in[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (do_write) begin
            if (write_done) begin
              write_done <= 1'b0;
            end else begin
              state        <= WRITE;
              mem.mem_addr <= {cpu_addr[XLEN-1:2], 2'b00};
              if (cpu_byte) begin
                mem.mem_we <= 4'b0001 << get_offset(cpu_addr);
                for (int i = 0; i < 4; i++) mem.mem_data_in[i] <= cpu_wdata[7:0];
              end else begin
                mem.mem_we <= 4'hF;
                for (int i = 0; i < 4; i++) mem.mem_data_in[i] <= cpu_wdata[8*i +: 8];
              end
            end
          end else begin
            write_done <= 1'b0;
            if (do_read && !rd_hit) begin
              state        <= FILL;
              counter      <= cnt_t'(1);
              mem.mem_addr <= {cpu_addr[XLEN-1:2], 2'b00};
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end else if (do_read) begin
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end
          end
        end
        FILL: begin
          counter <= counter + cnt_t'(1);
          if (counter == LAT) state <= IDLE;
        end
        WRITE: begin
          counter <= counter + cnt_t'(1);
          if (counter == LAT) begin
            mem.mem_we <= '0;
            write_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache. A transaction-level model (line arrays,
// model memory, hit/miss tallies) predicts per-cycle outputs; one negedge
// process compares them, and literal checks pin the model to known values.
module tb_data_cache;
  import cache_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, hit_count, miss_count;
  logic        cpu_read, cpu_write, cpu_byte, halted, cpu_stall;

  always #5 clk = ~clk;

  data_cache_if mem ();

  data_cache #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_byte   (cpu_byte),
    .halted     (halted),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem        (mem),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // ---------------- main memory (environment) ----------------
  function automatic logic [31:0] init_word(input int w);
    case (w)
      16:      return 32'hDEADBEEF;  // 0x40
      17:      return 32'h01020304;  // 0x44
      24:      return 32'hCAFEF00D;  // 0x60
      32:      return 32'h55AA55AA;  // 0x80
      40:      return 32'h0BADF00D;  // 0xA0
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] env_mem [0:255];
  logic        preload;

  always_comb begin
    for (int i = 0; i < 4; i++) mem.mem_data_out[i] = env_mem[mem.mem_addr[9:2]][8*i +: 8];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int w = 0; w < 256; w++) env_mem[w] <= init_word(w);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem.mem_we[b]) env_mem[mem.mem_addr[9:2]][8*b +: 8] <= mem.mem_data_in[b];
    end
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] m_mem   [0:255];
  int          m_hit, m_miss;

  logic        chk_en;
  logic        exp_stall;
  logic [3:0]  exp_we;
  logic [31:0] exp_hit, exp_miss, exp_addr, exp_wword, exp_rdata;
  bit          exp_addr_chk, exp_data_chk, exp_rdata_chk;

  // observations of the last transaction, used by the literal checks
  int          last_stalls, last_we_cycles;
  logic [3:0]  last_we;
  logic [31:0] last_rdata;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
      check("mem_we", 32'(mem.mem_we), 32'(exp_we));
      check("hit_count", hit_count, exp_hit);
      check("miss_count", miss_count, exp_miss);
      if (exp_addr_chk) check("mem_addr", mem.mem_addr, exp_addr);
      if (exp_data_chk)
        check("mem_data_in", {mem.mem_data_in[3], mem.mem_data_in[2], mem.mem_data_in[1], mem.mem_data_in[0]}, exp_wword);
      if (exp_rdata_chk) check("cpu_rdata", cpu_rdata, exp_rdata);
    end
  end

  task automatic set_idle_exp();
    exp_stall     = 1'b0;
    exp_we        = 4'h0;
    exp_hit       = 32'(m_hit);
    exp_miss      = 32'(m_miss);
    exp_addr_chk  = 1'b0;
    exp_data_chk  = 1'b0;
    exp_rdata_chk = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hit  = 0;
    m_miss = 0;
    set_idle_exp();
  endtask

  // One MEM-stage request held until the cache releases it, then one idle cycle.
  // Called at posedge+1.
  task automatic access(input bit wr, input bit rd, input bit byte_op, input bit halt,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          idx, w, n;
    logic [31:0] tag, wword;
    logic [3:0]  mask;
    bit          hit, is_wr, is_rd;
    is_wr = !halt && wr;
    is_rd = !halt && rd && !wr;
    idx   = int'((addr >> 2) % LINES);
    w     = int'((addr >> 2) % 256);
    tag   = addr / (4 * LINES);
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    if (is_wr)            n = LAT + 2;
    else if (is_rd && !hit) n = LAT + 1;
    else                  n = 0;
    if (byte_op) begin
      mask  = 4'b0001 << addr[1:0];
      wword = {4{wdata[7:0]}};
    end else begin
      mask  = 4'hF;
      wword = wdata;
    end
    cpu_addr = addr; cpu_wdata = wdata; cpu_read = rd; cpu_write = wr;
    cpu_byte = byte_op; halted = halt;
    last_stalls = 0; last_we_cycles = 0; last_we = 4'h0; last_rdata = '0;
    for (int c = 0; c <= n; c++) begin
      exp_stall     = (c < n);
      exp_hit       = 32'(m_hit);
      exp_miss      = 32'(m_miss + ((is_rd && !hit && c >= 1) ? 1 : 0));
      exp_we        = (is_wr && c >= 1 && c <= LAT + 1) ? mask : 4'h0;
      exp_addr_chk  = (is_wr || (is_rd && !hit)) && c >= 1 && c < n;
      exp_addr      = {addr[31:2], 2'b00};
      exp_data_chk  = is_wr && c >= 1 && c < n;
      exp_wword     = wword;
      exp_rdata_chk = is_rd && (c == n);
      exp_rdata     = hit ? m_data[idx] : m_mem[w];
      @(negedge clk);
      if (cpu_stall) last_stalls++;
      if (mem.mem_we != 4'h0) begin
        last_we_cycles++;
        last_we = mem.mem_we;
      end
      if (c == n) last_rdata = cpu_rdata;
      @(posedge clk); #1;
    end
    if (is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) begin
          m_mem[w][8*b +: 8] = wword[8*b +: 8];
          if (hit) m_data[idx][8*b +: 8] = wword[8*b +: 8];
        end
      end
    end else if (is_rd) begin
      if (!hit) begin
        m_miss++;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_data[idx]  = m_mem[w];
      end
      m_hit++;
    end
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte = 1'b0; halted = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
  endtask

  task automatic lw(input logic [31:0] addr);
    access(1'b0, 1'b1, 1'b0, 1'b0, addr, 32'h0);
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    access(1'b1, 1'b0, 1'b0, 1'b0, addr, data);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_b = 1'b0; preload = 1'b1; chk_en = 1'b0;
    cpu_addr = 32'h40; cpu_wdata = '0; cpu_read = 1'b1;
    cpu_write = 1'b0; cpu_byte = 1'b0; halted = 1'b0;
    for (int w = 0; w < 256; w++) m_mem[w] = init_word(w);
    model_reset();

    // reset state, with a load request already on the bus
    #12;
    check("reset cpu_stall", 32'(cpu_stall), 32'h0);
    check("reset mem_we", 32'(mem.mem_we), 32'h0);
    check("reset mem_addr", mem.mem_addr, 32'h0);
    check("reset cpu_rdata", cpu_rdata, 32'h0);
    check("reset hit_count", hit_count, 32'h0);
    check("reset miss_count", miss_count, 32'h0);
    @(posedge clk); #1;
    preload = 1'b0; cpu_read = 1'b0; rst_b = 1'b1;
    chk_en = 1'b1;

    // load miss then hit
    lw(32'h40);
    check("lw miss stall cycles", 32'(last_stalls), 32'd5);
    check("lw miss data", last_rdata, 32'hDEADBEEF);
    check("lw miss miss_count", miss_count, 32'd1);
    lw(32'h40);
    check("lw hit stall cycles", 32'(last_stalls), 32'd0);
    check("lw hit hit_count", hit_count, 32'd2);

    // store word on a cached line
    sw(32'h40, 32'h12345678);
    check("sw mem_we cycles", 32'(last_we_cycles), 32'd5);
    check("sw mem_we value", 32'(last_we), 32'hF);
    check("sw stall cycles", 32'(last_stalls), 32'd6);
    lw(32'h40);
    check("lw after sw stall", 32'(last_stalls), 32'd0);
    check("lw after sw data", last_rdata, 32'h12345678);

    // store byte to lane 3
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h43, 32'hFFFFFFAB);
    check("sb mem_we value", 32'(last_we), 32'h8);
    lw(32'h40);
    check("lw after sb data", last_rdata, 32'hAB345678);

    // conflict on index 0
    lw(32'h60);
    check("lw 0x60 data", last_rdata, 32'hCAFEF00D);
    lw(32'h40);
    check("lw 0x40 refill data", last_rdata, 32'hAB345678);
    check("conflict miss_count", miss_count, 32'd3);

    // write-no-allocate
    sw(32'h80, 32'h13579BDF);
    check("sw uncached mem_we cycles", 32'(last_we_cycles), 32'd5);
    lw(32'h80);
    check("lw after no-allocate stalls", 32'(last_stalls), 32'd5);
    check("lw after no-allocate data", last_rdata, 32'h13579BDF);
    check("no-allocate miss_count", miss_count, 32'd4);

    // a different index leaves line 0 intact
    lw(32'h44);
    check("lw 0x44 data", last_rdata, 32'h01020304);
    lw(32'h80);
    check("lw 0x80 still hits", 32'(last_stalls), 32'd0);

    // read and write together behave as a store
    access(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h2468ACE0);
    check("rd+wr mem_we cycles", 32'(last_we_cycles), 32'd5);
    lw(32'h80);
    check("lw after rd+wr data", last_rdata, 32'h2468ACE0);

    // halted: request ignored
    access(1'b0, 1'b1, 1'b0, 1'b1, 32'hA0, 32'h0);
    check("halted stall cycles", 32'(last_stalls), 32'd0);
    check("halted miss_count", miss_count, 32'd5);

    // reset during the third FILL cycle
    chk_en = 1'b0;
    cpu_addr = 32'hA0; cpu_read = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("mid-fill stall", 32'(cpu_stall), 32'h1);
    #2 rst_b = 1'b0;
    #1;
    check("fill abort cpu_stall", 32'(cpu_stall), 32'h0);
    check("fill abort mem_we", 32'(mem.mem_we), 32'h0);
    check("fill abort mem_addr", mem.mem_addr, 32'h0);
    check("fill abort miss_count", miss_count, 32'h0);
    @(posedge clk); #1;
    cpu_read = 1'b0; rst_b = 1'b1;
    model_reset();
    chk_en = 1'b1;
    lw(32'hA0);
    check("lw after fill abort stalls", 32'(last_stalls), 32'd5);
    check("lw after fill abort data", last_rdata, 32'h0BADF00D);
    check("lw after fill abort miss_count", miss_count, 32'd1);

    // reset in the middle of a store
    chk_en = 1'b0;
    cpu_addr = 32'hC0; cpu_wdata = 32'h11111111; cpu_write = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("mid-write mem_we", 32'(mem.mem_we), 32'hF);
    #2 rst_b = 1'b0;
    #1;
    check("write abort mem_we", 32'(mem.mem_we), 32'h0);
    check("write abort cpu_stall", 32'(cpu_stall), 32'h0);
    @(posedge clk); #1;
    cpu_write = 1'b0; rst_b = 1'b1;
    // memory saw at least one enabled edge before the abort
    m_mem[48] = 32'h11111111;
    model_reset();
    chk_en = 1'b1;
    lw(32'hA0);
    check("lw after write abort stalls", 32'(last_stalls), 32'd5);
    check("lw after write abort miss_count", miss_count, 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
